accum_fetch_sequencer: RTL and testbench

- Fetch/issue controller for the 8-bit accumulator core.
- Reads a byte-coded program from a shared program memory over a req/ack handshake and assembles opcode plus optional operand byte.
- Presents each decoded instruction to the core with a one-cycle issue strobe.
- Owns the program counter, including JUMP redirection and HALT, so the core no longer sequences itself.

---
 rtl/accum_fetch_sequencer.sv | 147 ++++++++++++++
 tb/tb_accum_fetch_sequencer.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accum_fetch_sequencer.sv
// Fetch/issue controller for the 8-bit accumulator core: fetches opcode plus optional operand,
// issues them to the core and owns the PC. Define ACCUM_SEQ_ICOUNT_EN to add the icount output.
module accum_fetch_sequencer #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned START_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack,
    input  logic              core_ready,
    output logic              core_issue,
    output logic [7:0]        core_instr,
    output logic [7:0]        core_data,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted
`ifdef ACCUM_SEQ_ICOUNT_EN
    ,
    output logic [15:0]       icount
`endif
);

    localparam logic [ADDR_W-1:0] StartPc = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] PcOne   = ADDR_W'(1);

    typedef enum logic [2:0] {
        StIdle,
        StFetchOp,
        StFetchArg,
        StIssue,
        StHalted
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        instr_q, instr_d;
    logic [7:0]        data_q, data_d;
    logic              start_ok;
    logic              consume;

    function automatic logic is_two_byte(input logic [3:0] cls);
        return cls inside {4'h1, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7};
    endfunction

    assign start_ok = start && (state_q == StIdle || state_q == StHalted);
    assign consume  = (state_q == StIssue) && core_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        data_d  = data_q;
        case (state_q)
            StIdle, StHalted: begin
                if (start) begin
                    pc_d    = StartPc;
                    state_d = StFetchOp;
                end
            end
            StFetchOp: begin
                if (mem_ack) begin
                    instr_d = mem_rdata;
                    pc_d    = pc_q + PcOne;
                    if (mem_rdata[7:4] == 4'hF) begin
                        state_d = StHalted;
                    end else if (is_two_byte(mem_rdata[7:4])) begin
                        state_d = StFetchArg;
                    end else begin
                        data_d  = 8'h00;
                        state_d = StIssue;
                    end
                end
            end
            StFetchArg: begin
                if (mem_ack) begin
                    data_d  = mem_rdata;
                    pc_d    = pc_q + PcOne;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (core_ready) begin
                    // JUMP redirects to the operand, truncated or zero-extended to the PC width
                    if (instr_q[7:4] == 4'h7) begin
                        pc_d = ADDR_W'(data_q);
                    end
                    state_d = StFetchOp;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            pc_q    <= StartPc;
            instr_q <= 8'h00;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            data_q  <= data_d;
        end
    end

    assign mem_req    = (state_q == StFetchOp) || (state_q == StFetchArg);
    assign mem_addr   = mem_req ? pc_q : '0;
    assign core_issue = (state_q == StIssue);
    assign core_instr = instr_q;
    assign core_data  = data_q;
    assign pc         = pc_q;
    assign busy       = !(state_q == StIdle || state_q == StHalted);
    assign halted     = (state_q == StHalted);

`ifdef ACCUM_SEQ_ICOUNT_EN
    logic [15:0] icount_q, icount_d;

    always_comb begin
        icount_d = icount_q;
        if (start_ok) begin
            icount_d = 16'h0000;
        end else if (consume && icount_q != 16'hFFFF) begin
            icount_d = icount_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            icount_q <= 16'h0000;
        end else begin
            icount_q <= icount_d;
        end
    end

    assign icount = icount_q;
`else
    logic unused_ok;
    assign unused_ok = start_ok ^ consume;
`endif

endmodule

// File: tb/tb_accum_fetch_sequencer.sv
// Self-checking bench for accum_fetch_sequencer: table vectors, corner-case sequences and
// randomized programs against a behavioural program-execution model.
module tb_accum_fetch_sequencer;

    localparam int unsigned AW = 8;

    logic          clk = 1'b0;
    logic          reset, start, mem_req, mem_ack, core_ready, core_issue, busy, halted;
    logic [AW-1:0] mem_addr, pc;
    logic [7:0]    mem_rdata, core_instr, core_data;
`ifdef ACCUM_SEQ_ICOUNT_EN
    logic [15:0]   icount;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [7:0] mem [256];
    bit         mem_auto = 1'b1;
    int         mem_wait = 0;
    int         wcnt = 0;
    bit         rand_ready = 1'b0;
    int         issue_cycles = 0;

    typedef struct {
        logic [7:0] instr;
        logic [7:0] data;
        int         t;
    } iss_t;

    iss_t       iss_q[$];
    iss_t       exp_q[$];
    bit         m_halt;
    logic [7:0] m_pc;

    typedef struct {
        logic [63:0] prog;
        int          n;
        logic [47:0] ei;
        logic [47:0] ed;
        logic [7:0]  epc;
    } vec_t;

    vec_t tbl[5];

    accum_fetch_sequencer #(.ADDR_W(AW), .START_ADDR(0)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .core_ready (core_ready),
        .core_issue (core_issue),
        .core_instr (core_instr),
        .core_data  (core_data),
        .pc         (pc),
        .busy       (busy),
        .halted     (halted)
`ifdef ACCUM_SEQ_ICOUNT_EN
        ,
        .icount     (icount)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory responder: ack arrives mem_wait cycles after the first cycle of the request
    always @(negedge clk) begin
        if (mem_auto) begin
            if (mem_ack) begin
                mem_ack = 1'b0;
                wcnt = mem_req ? 1 : 0;
            end else if (mem_req) begin
                if (wcnt >= mem_wait + 1) begin
                    mem_ack = 1'b1;
                    mem_rdata = mem[mem_addr];
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
            if (!mem_ack) mem_rdata = 8'($urandom);
        end
    end

    always @(negedge clk) begin
        #2;
        if (core_issue) issue_cycles++;
        if (core_issue && core_ready) iss_q.push_back('{core_instr, core_data, cyc});
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) core_ready = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rand_ready = 1'b0;
        reset = 1'b0;
        start = 1'b0;
        mem_auto = 1'b1;
        mem_ack = 1'b0;
        wcnt = 0;
        core_ready = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic clear_mem(input logic [7:0] fill);
        for (int i = 0; i < 256; i++) mem[i] = fill;
    endtask

    task automatic run_start();
        iss_q.delete();
        issue_cycles = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_halt(input string name);
        int n = 0;
        while (!halted && n < 3000) begin
            tick();
            n++;
        end
        chk({name, " halted"}, 32'(halted), 1);
    endtask

    // Reference: execute the program from address 0 by the opcode-class rules
    task automatic model(input int max_iss);
        int         p;
        logic [7:0] op;
        logic [7:0] d;
        p = 0;
        m_halt = 1'b0;
        exp_q.delete();
        while (exp_q.size() < max_iss) begin
            op = mem[p];
            p = (p + 1) % 256;
            if (op[7:4] == 4'hF) begin
                m_halt = 1'b1;
                break;
            end
            if (op[7:4] >= 4'h1 && op[7:4] <= 4'h7 && op[7:4] != 4'h2) begin
                d = mem[p];
                p = (p + 1) % 256;
                exp_q.push_back('{op, d, 0});
                if (op[7:4] == 4'h7) p = int'(d);
            end else begin
                exp_q.push_back('{op, 8'h00, 0});
            end
        end
        m_pc = 8'(p);
    endtask

    initial begin
        int  n;
        int  nreq;
        bit  hit;

        reset = 1'b0;
        start = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = 8'h00;
        core_ready = 1'b1;
        clear_mem(8'hF0);
        #3;
        chk("rst mem_req", 32'(mem_req), 0);
        chk("rst mem_addr", 32'(mem_addr), 0);
        chk("rst core_issue", 32'(core_issue), 0);
        chk("rst core_instr", 32'(core_instr), 0);
        chk("rst core_data", 32'(core_data), 0);
        chk("rst pc", 32'(pc), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst halted", 32'(halted), 0);

        tbl[0] = '{64'h0000_F020_0530_2A10, 3, 48'h0000_0020_3010, 48'h0000_0000_052A, 8'h06};
        tbl[1] = '{64'h0000_00F0_F1F1_0470, 1, 48'h0000_0000_0070, 48'h0000_0000_0004, 8'h05};
        tbl[2] = '{64'h0000_0000_0000_00F0, 0, 48'h0, 48'h0, 8'h01};
        tbl[3] = '{64'h0000_0000_F3E5_8020, 3, 48'h0000_00E5_8020, 48'h0, 8'h04};
        tbl[4] = '{64'h00F0_3360_0F50_FF40, 3, 48'h0000_0060_5040, 48'h0000_0033_0FFF, 8'h07};

        for (int v = 0; v < 5; v++) begin
            do_reset();
            clear_mem(8'hF0);
            for (int b = 0; b < 8; b++) mem[b] = tbl[v].prog[8*b +: 8];
            mem_wait = 0;
            run_start();
            wait_halt($sformatf("vec%0d", v));
            chk($sformatf("vec%0d count", v), 32'(iss_q.size()), 32'(tbl[v].n));
            for (int i = 0; i < tbl[v].n && i < iss_q.size(); i++) begin
                chk($sformatf("vec%0d instr%0d", v, i), 32'(iss_q[i].instr), 32'(tbl[v].ei[8*i +: 8]));
                chk($sformatf("vec%0d data%0d", v, i), 32'(iss_q[i].data), 32'(tbl[v].ed[8*i +: 8]));
            end
            chk($sformatf("vec%0d pc", v), 32'(pc), 32'(tbl[v].epc));
            chk($sformatf("vec%0d busy", v), 32'(busy), 0);
            chk($sformatf("vec%0d issue cycles", v), 32'(issue_cycles), 32'(tbl[v].n));
`ifdef ACCUM_SEQ_ICOUNT_EN
            chk($sformatf("vec%0d icount", v), 32'(icount), 32'(tbl[v].n));
`endif
            if (v == 0 && iss_q.size() >= 3) begin
                chk("spacing 2-byte", 32'(iss_q[1].t - iss_q[0].t), 5);
                chk("spacing 1-byte", 32'(iss_q[2].t - iss_q[1].t), 3);
            end
        end

        // Asynchronous reset while the operand fetch is pending
        do_reset();
        clear_mem(8'hF0);
        mem[0] = 8'h10;
        mem[1] = 8'h2A;
        mem_wait = 20;
        run_start();
        n = 0;
        while (!(mem_req && mem_addr == 8'h01) && n < 100) begin
            tick();
            n++;
        end
        chk("midarg reached", 32'(mem_req && mem_addr == 8'h01), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("midarg mem_req", 32'(mem_req), 0);
        chk("midarg pc", 32'(pc), 0);
        chk("midarg busy", 32'(busy), 0);
        mem_auto = 1'b0;
        mem_ack = 1'b1;
        mem_rdata = 8'h77;
        tick();
        reset = 1'b1;
        tick();
        tick();
        chk("stale ack pc", 32'(pc), 0);
        chk("stale ack busy", 32'(busy), 0);
        chk("stale ack mem_req", 32'(mem_req), 0);
        mem_ack = 1'b0;
        wcnt = 0;
        mem_auto = 1'b1;

        // JUMP redirection
        do_reset();
        clear_mem(8'hF0);
        mem[8'h00] = 8'h70;
        mem[8'h01] = 8'h10;
        mem[8'h10] = 8'hF0;
        mem_wait = 0;
        run_start();
        n = 0;
        while (!(mem_req && iss_q.size() > 0) && n < 200) begin
            tick();
            n++;
        end
        chk("jump fetch seen", 32'(mem_req && iss_q.size() > 0), 1);
        chk("jump next mem_addr", 32'(mem_addr), 32'h10);
        wait_halt("jump");
        chk("jump count", 32'(iss_q.size()), 1);
        if (iss_q.size() > 0) begin
            chk("jump instr", 32'(iss_q[0].instr), 32'h70);
            chk("jump data", 32'(iss_q[0].data), 32'h10);
        end
        chk("jump pc", 32'(pc), 32'h11);

        // Backpressure, with a start pulse while busy
        do_reset();
        clear_mem(8'hF0);
        mem[0] = 8'h30;
        mem[1] = 8'h05;
        mem[2] = 8'h20;
        mem_wait = 0;
        core_ready = 1'b0;
        run_start();
        n = 0;
        hit = 1'b0;
        while (!hit && n < 100) begin
            @(negedge clk);
            #1;
            hit = core_issue;
            n++;
        end
        chk("bp issue seen", 32'(hit), 1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            chk($sformatf("bp issue c%0d", i), 32'(core_issue), 1);
            chk($sformatf("bp instr c%0d", i), 32'(core_instr), 32'h30);
            chk($sformatf("bp data c%0d", i), 32'(core_data), 32'h05);
            chk($sformatf("bp mem_req c%0d", i), 32'(mem_req), 0);
            chk($sformatf("bp pc c%0d", i), 32'(pc), 32'h02);
            if (i == 1) start = 1'b1;
            if (i == 2) start = 1'b0;
            if (i == 3) begin
                @(posedge clk);
                #1;
                core_ready = 1'b1;
            end
        end
        @(negedge clk);
        #1;
        chk("bp issue dropped", 32'(core_issue), 0);
        wait_halt("bp");
        chk("bp issue cycles", 32'(issue_cycles), 6);
        chk("bp count", 32'(iss_q.size()), 2);
        if (iss_q.size() > 1) chk("bp second instr", 32'(iss_q[1].instr), 32'h20);
        chk("bp pc", 32'(pc), 32'h04);
`ifdef ACCUM_SEQ_ICOUNT_EN
        chk("bp icount", 32'(icount), 2);
`endif

        // Memory wait states
        do_reset();
        clear_mem(8'hF0);
        mem[0] = 8'h20;
        mem_wait = 3;
        run_start();
        nreq = 0;
        n = 0;
        hit = 1'b0;
        while (!hit && n < 50) begin
            @(negedge clk);
            #1;
            if (mem_req) begin
                nreq++;
                chk($sformatf("ws mem_addr c%0d", nreq), 32'(mem_addr), 0);
            end
            hit = mem_ack;
            n++;
        end
        chk("ws req cycles", 32'(nreq), 5);
        wait_halt("ws");
        if (iss_q.size() > 0) begin
            chk("ws instr", 32'(iss_q[0].instr), 32'h20);
            chk("ws data", 32'(iss_q[0].data), 32'h00);
        end
        chk("ws count", 32'(iss_q.size()), 1);

        // PC wrap: operand fetched at FF comes from 00
        do_reset();
        clear_mem(8'hF0);
        mem[8'h00] = 8'h70;
        mem[8'h01] = 8'hFF;
        mem[8'hFF] = 8'h10;
        mem_wait = 0;
        run_start();
        wait_halt("wrap");
        chk("wrap count", 32'(iss_q.size()), 2);
        if (iss_q.size() > 1) begin
            chk("wrap instr", 32'(iss_q[1].instr), 32'h10);
            chk("wrap data", 32'(iss_q[1].data), 32'h70);
        end
        chk("wrap pc", 32'(pc), 32'h02);

        // Randomized programs, waits and backpressure
        for (int r = 0; r < 10; r++) begin
            do_reset();
            for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
            mem_wait = $urandom_range(0, 2);
            model(12);
            rand_ready = 1'b1;
            run_start();
            n = 0;
            while (!(m_halt ? halted : (iss_q.size() >= exp_q.size())) && n < 4000) begin
                tick();
                n++;
            end
            chk($sformatf("rand%0d done", r), 32'(n < 4000), 1);
            if (m_halt) begin
                chk($sformatf("rand%0d count", r), 32'(iss_q.size()), 32'(exp_q.size()));
                chk($sformatf("rand%0d pc", r), 32'(pc), 32'(m_pc));
            end
            for (int i = 0; i < exp_q.size() && i < iss_q.size(); i++) begin
                chk($sformatf("rand%0d instr%0d", r, i), 32'(iss_q[i].instr), 32'(exp_q[i].instr));
                chk($sformatf("rand%0d data%0d", r, i), 32'(iss_q[i].data), 32'(exp_q[i].data));
            end
            rand_ready = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
